// File: rtl/writeback_stage_if.sv
// Writeback-stage bus: memory-stage results and decode issue info in, register-file
// write port, scoreboard and performance counters out.
interface writeback_stage_if #(
  parameter int unsigned RegWidth    = 16,
  parameter int unsigned OpcodeWidth = 8
);
  logic                   I_LOCK;
  logic [RegWidth-1:0]    I_ALUOut;
  logic [RegWidth-1:0]    I_MemOut;
  logic [OpcodeWidth-1:0] I_Opcode;
  logic [3:0]             I_DestRegIdx;
  logic                   I_FetchStall;
  logic                   I_DepStall;
  logic                   I_IssueValid;
  logic [3:0]             I_IssueRegIdx;
  logic                   O_WriteEnable;
  logic [3:0]             O_WriteRegIdx;
  logic [RegWidth-1:0]    O_WriteValue;
  logic [15:0]            O_RegBusy;
  logic [15:0]            O_RetireCount;
  logic [15:0]            O_StallCount;
  logic                   O_ScoreErr;

  modport master (
    output I_LOCK, I_ALUOut, I_MemOut, I_Opcode, I_DestRegIdx, I_FetchStall, I_DepStall,
           I_IssueValid, I_IssueRegIdx,
    input  O_WriteEnable, O_WriteRegIdx, O_WriteValue, O_RegBusy, O_RetireCount,
           O_StallCount, O_ScoreErr
  );

  modport slave (
    input  I_LOCK, I_ALUOut, I_MemOut, I_Opcode, I_DestRegIdx, I_FetchStall, I_DepStall,
           I_IssueValid, I_IssueRegIdx,
    output O_WriteEnable, O_WriteRegIdx, O_WriteValue, O_RegBusy, O_RetireCount,
           O_StallCount, O_ScoreErr
  );
endinterface

// File: rtl/writeback_stage.sv
// Fifth pipeline stage: selects the result, drives the register-file write port, and owns
// the pending-write scoreboard plus retire/stall counters. All state moves on negedge.
module writeback_stage (
  input  logic             I_CLOCK,
  input  logic             I_RESET,
  writeback_stage_if.slave wb
);
  // Opcode encodings shared with the rest of the pipeline.
  localparam logic [7:0] OP_LDW   = 8'h40;
  localparam logic [7:0] OP_STW   = 8'h41;
  localparam logic [7:0] OP_BRN   = 8'h50;
  localparam logic [7:0] OP_BRNZP = 8'h57;
  localparam logic [7:0] OP_JMP   = 8'h60;

  logic        ret;
  logic        writes;
  logic        wr;
  logic [15:0] result;
  logic [15:0] inc;
  logic [15:0] dec;

  logic             we_q;
  logic [3:0]       idx_q;
  logic [15:0]      val_q;
  logic [15:0]      ret_cnt_q;
  logic [15:0]      stall_cnt_q;
  logic [15:0][1:0] cnt_q, cnt_d;
  logic             err_q, err_d;
  logic [15:0]      busy;

  always_comb begin
    ret = wb.I_LOCK & ~wb.I_FetchStall & ~wb.I_DepStall;
    case (wb.I_Opcode) inside
      OP_STW, OP_JMP, [OP_BRN:OP_BRNZP]: writes = 1'b0;
      default:                           writes = 1'b1;
    endcase
    wr     = ret & writes;
    result = (wb.I_Opcode == OP_LDW) ? wb.I_MemOut : wb.I_ALUOut;
    inc    = {16{wb.I_LOCK & wb.I_IssueValid}} & (16'd1 << wb.I_IssueRegIdx);
    dec    = {16{wr}} & (16'd1 << wb.I_DestRegIdx);
  end

  // Saturating pending counters; an issue and a retire on the same register cancel.
  always_comb begin
    cnt_d = cnt_q;
    err_d = err_q;
    for (int r = 0; r < 16; r++) begin
      case ({inc[r], dec[r]})
        2'b10: begin
          if (cnt_q[r] == 2'd3) err_d = 1'b1;
          else                  cnt_d[r] = cnt_q[r] + 2'd1;
        end
        2'b01: begin
          if (cnt_q[r] == 2'd0) err_d = 1'b1;
          else                  cnt_d[r] = cnt_q[r] - 2'd1;
        end
        default: ;
      endcase
    end
  end

  always_ff @(negedge I_CLOCK or posedge I_RESET) begin
    if (I_RESET) begin
      we_q        <= 1'b0;
      idx_q       <= 4'd0;
      val_q       <= 16'd0;
      ret_cnt_q   <= 16'd0;
      stall_cnt_q <= 16'd0;
      cnt_q       <= '0;
      err_q       <= 1'b0;
    end else begin
      we_q <= wr;
      if (wr) begin
        idx_q <= wb.I_DestRegIdx;
        val_q <= result;
      end
      if (ret) ret_cnt_q <= ret_cnt_q + 16'd1;
      if (wb.I_LOCK & (wb.I_FetchStall | wb.I_DepStall)) stall_cnt_q <= stall_cnt_q + 16'd1;
      cnt_q <= cnt_d;
      err_q <= err_d;
    end
  end

  always_comb begin
    for (int r = 0; r < 16; r++) busy[r] = |cnt_q[r];
  end

  assign wb.O_WriteEnable = we_q;
  assign wb.O_WriteRegIdx = idx_q;
  assign wb.O_WriteValue  = val_q;
  assign wb.O_RegBusy     = busy;
  assign wb.O_RetireCount = ret_cnt_q;
  assign wb.O_StallCount  = stall_cnt_q;
  assign wb.O_ScoreErr    = err_q;
endmodule

// File: tb/tb_writeback_stage.sv
// Randomized and directed bench for writeback_stage against a pending-count reference model.
module tb_writeback_stage;
  localparam logic [7:0] OP_ADD = 8'h01;
  localparam logic [7:0] OP_LDW = 8'h40;
  localparam logic [7:0] OP_STW = 8'h41;
  localparam logic [7:0] OP_BRZ = 8'h52;
  localparam logic [7:0] OP_JMP = 8'h60;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  writeback_stage_if bus ();
  writeback_stage dut (.I_CLOCK(clk), .I_RESET(rst), .wb(bus));

  int          checks = 0;
  int          errors = 0;
  int          m_cnt[16];
  logic        m_err;
  logic        m_we;
  logic [3:0]  m_idx;
  logic [15:0] m_val;
  logic [15:0] m_ret;
  logic [15:0] m_stall;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] model_busy();
    logic [15:0] b;
    for (int r = 0; r < 16; r++) b[r] = (m_cnt[r] != 0);
    return b;
  endfunction

  task automatic model_reset();
    for (int r = 0; r < 16; r++) m_cnt[r] = 0;
    m_err = 0; m_we = 0; m_idx = 0; m_val = 0; m_ret = 0; m_stall = 0;
  endtask

  task automatic check_all(input string tag);
    check({tag, "_we"},    {31'd0, bus.O_WriteEnable}, {31'd0, m_we});
    check({tag, "_idx"},   {28'd0, bus.O_WriteRegIdx}, {28'd0, m_idx});
    check({tag, "_val"},   {16'd0, bus.O_WriteValue},  {16'd0, m_val});
    check({tag, "_busy"},  {16'd0, bus.O_RegBusy},     {16'd0, model_busy()});
    check({tag, "_ret"},   {16'd0, bus.O_RetireCount}, {16'd0, m_ret});
    check({tag, "_stall"}, {16'd0, bus.O_StallCount},  {16'd0, m_stall});
    check({tag, "_err"},   {31'd0, bus.O_ScoreErr},    {31'd0, m_err});
  endtask

  // Drive at posedge, let the DUT sample at negedge, then advance the model and compare.
  task automatic cycle(input logic lock, input logic fs, input logic ds, input logic [7:0] op,
                       input logic [3:0] dest, input logic [15:0] alu, input logic [15:0] mem,
                       input logic iv, input logic [3:0] iidx, input bit chk);
    bit ret, writes, wr, inc, dec;
    @(posedge clk);
    bus.I_LOCK = lock; bus.I_FetchStall = fs; bus.I_DepStall = ds; bus.I_Opcode = op;
    bus.I_DestRegIdx = dest; bus.I_ALUOut = alu; bus.I_MemOut = mem;
    bus.I_IssueValid = iv; bus.I_IssueRegIdx = iidx;
    @(negedge clk);
    ret    = lock && !fs && !ds;
    writes = !(op == OP_STW || op == OP_JMP || (op >= 8'h50 && op <= 8'h57));
    wr     = ret && writes;
    m_we   = wr;
    if (wr) begin
      m_idx = dest;
      m_val = (op == OP_LDW) ? mem : alu;
    end
    if (ret) m_ret = m_ret + 16'd1;
    if (lock && (fs || ds)) m_stall = m_stall + 16'd1;
    inc = lock && iv;
    dec = wr;
    if (inc && dec && iidx == dest) begin
      // same register: no net change
    end else begin
      if (inc) begin
        if (m_cnt[iidx] == 3) m_err = 1; else m_cnt[iidx]++;
      end
      if (dec) begin
        if (m_cnt[dest] == 0) m_err = 1; else m_cnt[dest]--;
      end
    end
    #1;
    if (chk) check_all("cyc");
  endtask

  logic [7:0]  ops[6] = '{OP_ADD, 8'h02, OP_LDW, OP_STW, OP_BRZ, OP_JMP};
  logic [15:0] r0;

  initial begin
    rst = 1'b1;
    bus.I_LOCK = 0; bus.I_FetchStall = 0; bus.I_DepStall = 0; bus.I_Opcode = OP_ADD;
    bus.I_DestRegIdx = 0; bus.I_ALUOut = 0; bus.I_MemOut = 0;
    bus.I_IssueValid = 0; bus.I_IssueRegIdx = 0;
    model_reset();
    #12 rst = 1'b0;
    check_all("reset");

    // ALU op to R3; issue of R3 in the same cycle keeps the scoreboard balanced.
    cycle(1, 0, 0, OP_ADD, 4'd3, 16'h1234, 16'h0000, 1, 4'd3, 1);
    check("alu_we", {31'd0, bus.O_WriteEnable}, 32'd1);
    check("alu_idx", {28'd0, bus.O_WriteRegIdx}, 32'd3);
    check("alu_val", {16'd0, bus.O_WriteValue}, 32'h1234);
    check("alu_ret", {16'd0, bus.O_RetireCount}, 32'd1);

    cycle(1, 0, 0, OP_LDW, 4'd5, 16'h03FC, 16'hBEEF, 1, 4'd5, 1);
    check("ldw_val", {16'd0, bus.O_WriteValue}, 32'hBEEF);

    r0 = m_ret;
    cycle(1, 0, 0, OP_STW, 4'd6, 16'h1111, 16'h2222, 0, 4'd0, 1);
    check("stw_we", {31'd0, bus.O_WriteEnable}, 32'd0);
    cycle(1, 0, 0, OP_BRZ, 4'd6, 16'h3333, 16'h4444, 0, 4'd0, 1);
    check("br_we", {31'd0, bus.O_WriteEnable}, 32'd0);
    check("stbr_ret", {16'd0, bus.O_RetireCount}, {16'd0, r0 + 16'd2});

    // Scoreboard saturation on R2, then cancel, then drain.
    for (int i = 0; i < 3; i++) cycle(1, 0, 0, OP_STW, 4'd0, 0, 0, 1, 4'd2, 1);
    check("r2_busy3", {31'd0, bus.O_RegBusy[2]}, 32'd1);
    check("r2_noerr", {31'd0, bus.O_ScoreErr}, 32'd0);
    cycle(1, 0, 0, OP_STW, 4'd0, 0, 0, 1, 4'd2, 1);
    check("r2_ovf", {31'd0, bus.O_ScoreErr}, 32'd1);
    cycle(1, 0, 0, OP_ADD, 4'd2, 16'h0A0A, 0, 1, 4'd2, 1);
    for (int i = 0; i < 3; i++) begin
      cycle(1, 0, 0, OP_ADD, 4'd2, 16'h0B00 + 16'(i), 0, 0, 4'd0, 1);
      check("r2_drain", {31'd0, bus.O_RegBusy[2]}, (i == 2) ? 32'd0 : 32'd1);
    end

    r0 = m_stall;
    for (int i = 0; i < 4; i++) begin
      cycle(1, 0, 1, OP_ADD, 4'd9, 16'hDEAD, 0, 0, 4'd0, 1);
      check("dep_we", {31'd0, bus.O_WriteEnable}, 32'd0);
    end
    check("dep_stall", {16'd0, bus.O_StallCount}, {16'd0, r0 + 16'd4});

    // Asynchronous reset between edges with R7 pending and a write pulse live.
    cycle(1, 1, 0, OP_ADD, 4'd0, 0, 0, 1, 4'd7, 1);
    cycle(1, 0, 0, OP_ADD, 4'd9, 16'h5A5A, 0, 1, 4'd9, 1);
    check("pre_rst_we", {31'd0, bus.O_WriteEnable}, 32'd1);
    check("pre_rst_r7", {31'd0, bus.O_RegBusy[7]}, 32'd1);
    #1 rst = 1'b1;
    #1;
    check("arst_we", {31'd0, bus.O_WriteEnable}, 32'd0);
    check("arst_idx", {28'd0, bus.O_WriteRegIdx}, 32'd0);
    check("arst_val", {16'd0, bus.O_WriteValue}, 32'd0);
    check("arst_busy", {16'd0, bus.O_RegBusy}, 32'd0);
    check("arst_ret", {16'd0, bus.O_RetireCount}, 32'd0);
    check("arst_stall", {16'd0, bus.O_StallCount}, 32'd0);
    check("arst_err", {31'd0, bus.O_ScoreErr}, 32'd0);
    rst = 1'b0;
    model_reset();

    for (int i = 0; i < 400; i++) begin
      cycle(($urandom % 8) != 0, ($urandom % 6) == 0, ($urandom % 6) == 0,
            ops[$urandom % 6], 4'($urandom), 16'($urandom), 16'($urandom),
            1'($urandom), 4'($urandom), 1);
    end

    // Drive the retire counter to 0xFFFF with stores, then wrap it.
    while (m_ret != 16'hFFFF) cycle(1, 0, 0, OP_STW, 4'd0, 0, 0, 0, 4'd0, 0);
    check("pre_wrap", {16'd0, bus.O_RetireCount}, 32'h0000FFFF);
    cycle(1, 0, 0, OP_STW, 4'd0, 0, 0, 0, 4'd0, 1);
    check("wrap", {16'd0, bus.O_RetireCount}, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
